// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, control-unit states, ALU operations,
// datapath mux select codes and the opcode class bundle.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3,
        OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_ADDI = 4'h6, OP_LDI  = 4'h7,
        OP_LD   = 4'h8, OP_ST   = 4'h9, OP_BEQ  = 4'hA, OP_BNE  = 4'hB,
        OP_JMP  = 4'hC, OP_ILL0 = 4'hD, OP_ILL1 = 4'hE, OP_HLT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } cu_state_t;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2,
        ALU_AND  = 4'd3, ALU_OR  = 4'd4, ALU_XOR = 4'd5
    } alu_op_t;

    // PC source
    localparam logic       PC_SEL_ADDER  = 1'b0;
    localparam logic       PC_SEL_ACC    = 1'b1;
    // PC adder increment
    localparam logic [1:0] ADDER_INC     = 2'd0;
    localparam logic [1:0] ADDER_SE4     = 2'd1;
    localparam logic [1:0] ADDER_SE8     = 2'd2;
    localparam logic [1:0] ADDER_SE12    = 2'd3;
    // second ALU operand source
    localparam logic       SRC_REGB      = 1'b0;
    localparam logic       SRC_SE4       = 1'b1;
    // register-file write data
    localparam logic [1:0] DATAW_ACC     = 2'd0;
    localparam logic [1:0] DATAW_MDR     = 2'd1;
    localparam logic [1:0] DATAW_SE8     = 2'd2;

    typedef struct packed {
        logic alu;
        logic ldi;
        logic mem;
        logic branch;
        logic jmp;
        logic nop;
        logic illegal;
        logic halt;
    } op_class_t;

    // ALU operation for an ALU-class opcode; ADDI reuses ADD with se4 operand
    function automatic alu_op_t alu_of(input opcode_t op);
        case (op)
            OP_ADD, OP_ADDI: alu_of = ALU_ADD;
            OP_SUB:          alu_of = ALU_SUB;
            OP_AND:          alu_of = ALU_AND;
            OP_OR:           alu_of = ALU_OR;
            OP_XOR:          alu_of = ALU_XOR;
            default:         alu_of = ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Opcode class decoder: purely combinational opcode -> instruction class.
module control_decoder
    import cpu_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        cls
);

    opcode_t op;
    assign op = opcode_t'(opcode);

    // one-hot-ish class flags; halt covers both illegal opcodes and HLT
    always_comb begin
        cls = '0;
        case (op)
            OP_NOP:                                   cls.nop    = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_ADDI:                                  cls.alu    = 1'b1;
            OP_LDI:                                   cls.ldi    = 1'b1;
            OP_LD, OP_ST:                             cls.mem    = 1'b1;
            OP_BEQ, OP_BNE:                           cls.branch = 1'b1;
            OP_JMP:                                   cls.jmp    = 1'b1;
            OP_ILL0, OP_ILL1: begin
                cls.illegal = 1'b1;
                cls.halt    = 1'b1;
            end
            default:                                  cls.halt   = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer
// driving datapath write enables and mux selects.
// Optional feature: define CU_INSTRET_CNT_EN to add the 16-bit retired
// instruction counter output instret.
module control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] instr,
    input  logic              flag_z,
    input  logic              mem_rdy,
    output logic              pc_we,
    output logic              ir_we,
    output logic              rf_we,
    output logic              ram_we,
    output logic              mar_we,
    output logic              mdr_we,
    output logic              acc_we,
    output logic              rega_we,
    output logic              regb_we,
    output logic              flags_we,
    output logic [3:0]        alu_op,
    output logic              mux_pc_sel,
    output logic [1:0]        mux_adder_sel,
    output logic              mux_reg2_sel,
    output logic              mux_alu_sel,
    output logic [1:0]        mux_dataw_sel,
    output logic              mem_req,
    output logic              halted,
    output logic              illegal
`ifdef CU_INSTRET_CNT_EN
    ,
    output logic [15:0]       instret
`endif
);

    cu_state_t state, state_nx;
    logic      ill_q;
    op_class_t cls;
    opcode_t   op;
    logic      unused_instr;

    assign op           = opcode_t'(instr[DATA_W-1 -: OPC_W]);
    assign unused_instr = ^instr[DATA_W-OPC_W-1:0];

    control_decoder #(.OPC_W(OPC_W)) u_dec (
        .opcode (instr[DATA_W-1 -: OPC_W]),
        .cls    (cls)
    );

    // state register plus the sticky "halted on an illegal opcode" bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            ill_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == DECODE) ill_q <= cls.illegal;
        end
    end

    // next state and datapath controls; everything held low during reset
    always_comb begin
        state_nx      = state;
        pc_we         = 1'b0;
        ir_we         = 1'b0;
        rf_we         = 1'b0;
        ram_we        = 1'b0;
        mar_we        = 1'b0;
        mdr_we        = 1'b0;
        acc_we        = 1'b0;
        rega_we       = 1'b0;
        regb_we       = 1'b0;
        flags_we      = 1'b0;
        alu_op        = ALU_NONE;
        mux_pc_sel    = PC_SEL_ADDER;
        mux_adder_sel = ADDER_INC;
        mux_reg2_sel  = SRC_REGB;
        mux_alu_sel   = SRC_REGB;
        mux_dataw_sel = DATAW_ACC;
        mem_req       = 1'b0;
        halted        = 1'b0;
        illegal       = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_rdy) begin
                        ir_we    = 1'b1;
                        pc_we    = 1'b1;
                        state_nx = DECODE;
                    end
                end
                DECODE: begin
                    rega_we  = 1'b1;
                    regb_we  = 1'b1;
                    state_nx = cls.halt ? HALT : EXEC;
                end
                EXEC: begin
                    state_nx = FETCH;
                    if (cls.alu) begin
                        acc_we   = 1'b1;
                        flags_we = 1'b1;
                        alu_op   = alu_of(op);
                        if (op == OP_ADDI) begin
                            mux_alu_sel  = SRC_SE4;
                            mux_reg2_sel = SRC_SE4;
                        end
                        state_nx = WB;
                    end else if (cls.ldi) begin
                        rf_we         = 1'b1;
                        mux_dataw_sel = DATAW_SE8;
                    end else if (cls.mem) begin
                        // effective address rs + se4 lands in both MAR and ACC
                        alu_op       = ALU_ADD;
                        mux_alu_sel  = SRC_SE4;
                        mux_reg2_sel = SRC_SE4;
                        mar_we       = 1'b1;
                        acc_we       = 1'b1;
                        state_nx     = MEM;
                    end else if (cls.branch) begin
                        if ((op == OP_BEQ) ? flag_z : !flag_z) begin
                            pc_we         = 1'b1;
                            mux_adder_sel = ADDER_SE8;
                        end
                    end else if (cls.jmp) begin
                        pc_we         = 1'b1;
                        mux_adder_sel = ADDER_SE12;
                    end else if (cls.nop) begin
                        state_nx = FETCH;
                    end
                end
                MEM: begin
                    mem_req = 1'b1;
                    if (mem_rdy) begin
                        if (op == OP_ST) begin
                            ram_we   = 1'b1;
                            state_nx = FETCH;
                        end else begin
                            mdr_we   = 1'b1;
                            state_nx = WB;
                        end
                    end
                end
                WB: begin
                    rf_we         = 1'b1;
                    mux_dataw_sel = (op == OP_LD) ? DATAW_MDR : DATAW_ACC;
                    state_nx      = FETCH;
                end
                HALT: begin
                    halted  = 1'b1;
                    illegal = ill_q;
                end
                default: state_nx = FETCH;
            endcase
        end
    end

`ifdef CU_INSTRET_CNT_EN
    // count retirements: any return to FETCH from a later stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret <= '0;
        else if (state != FETCH && state_nx == FETCH)
            instret <= instret + 16'd1;
    end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-instruction cycle plan built from
// the instruction timing rules feeds a driver; a negedge monitor compares.
module tb_control_unit;

    typedef struct packed {
        logic       pc_we, ir_we, rf_we, ram_we, mar_we, mdr_we;
        logic       acc_we, rega_we, regb_we, flags_we;
        logic [3:0] alu_op;
        logic       pc_sel;
        logic [1:0] adder;
        logic       reg2, alu_sel;
        logic [1:0] dataw;
        logic       mem_req, halted, illegal;
    } outs_t;

    typedef struct {
        logic [15:0] ins;
        logic        rdy, fz, rstn;
        outs_t       exp;
        logic [15:0] ir;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        flag_z, mem_rdy;
    logic        pc_we, ir_we, rf_we, ram_we, mar_we, mdr_we, acc_we;
    logic        rega_we, regb_we, flags_we;
    logic [3:0]  alu_op;
    logic        mux_pc_sel, mux_reg2_sel, mux_alu_sel;
    logic [1:0]  mux_adder_sel, mux_dataw_sel;
    logic        mem_req, halted, illegal;
`ifdef CU_INSTRET_CNT_EN
    logic [15:0] instret;
`endif

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .flag_z(flag_z), .mem_rdy(mem_rdy),
        .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .ram_we(ram_we), .mar_we(mar_we),
        .mdr_we(mdr_we), .acc_we(acc_we), .rega_we(rega_we), .regb_we(regb_we),
        .flags_we(flags_we), .alu_op(alu_op), .mux_pc_sel(mux_pc_sel),
        .mux_adder_sel(mux_adder_sel), .mux_reg2_sel(mux_reg2_sel),
        .mux_alu_sel(mux_alu_sel), .mux_dataw_sel(mux_dataw_sel),
        .mem_req(mem_req), .halted(halted), .illegal(illegal)
`ifdef CU_INSTRET_CNT_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    rec_t        stim_q[$];
    rec_t        exp_q[$];
    logic [15:0] m_instret;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    task automatic push(input logic [15:0] ins, input logic rdy, input logic fz,
                        input logic rstn, input outs_t o);
        rec_t r;
        r.ins = ins; r.rdy = rdy; r.fz = fz; r.rstn = rstn; r.exp = o; r.ir = m_instret;
        stim_q.push_back(r);
    endtask

    task automatic push_rst();
        m_instret = 16'd0;
        push(16'h0000, 1'b1, 1'b0, 1'b0, outs_t'('0));
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Plan one instruction: fetch waits wf, memory waits wm, branch flag fz_ex
    // (-1 = random), reset asserted at memory-wait index abort_at (-1 = none),
    // halt_cycles spent in HALT for halting opcodes.
    task automatic plan(input logic [15:0] ins, input int wf, input int wm,
                        input int fz_ex, input int abort_at, input int halt_cycles);
        outs_t      o;
        logic [3:0] op = ins[15:12];
        logic       fz;
        for (int i = 0; i < wf; i++) begin
            o = '0; o.mem_req = 1'b1;
            push(ins, 1'b0, rbit(), 1'b1, o);
        end
        o = '0; o.mem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
        push(ins, 1'b1, rbit(), 1'b1, o);
        o = '0; o.rega_we = 1'b1; o.regb_we = 1'b1;
        push(ins, rbit(), rbit(), 1'b1, o);
        if (op >= 4'hD) begin
            for (int i = 0; i < halt_cycles; i++) begin
                o = '0; o.halted = 1'b1; o.illegal = (op != 4'hF);
                push(ins, rbit(), rbit(), 1'b1, o);
            end
            return;
        end
        fz = (fz_ex < 0) ? rbit() : 1'(fz_ex);
        o = '0;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                o.acc_we = 1'b1; o.flags_we = 1'b1; o.alu_op = op;
            end
            4'h6: begin
                o.acc_we = 1'b1; o.flags_we = 1'b1; o.alu_op = 4'd1;
                o.alu_sel = 1'b1; o.reg2 = 1'b1;
            end
            4'h7: begin o.rf_we = 1'b1; o.dataw = 2'd2; end
            4'h8, 4'h9: begin
                o.alu_op = 4'd1; o.alu_sel = 1'b1; o.reg2 = 1'b1;
                o.mar_we = 1'b1; o.acc_we = 1'b1;
            end
            4'hA: if (fz)  begin o.pc_we = 1'b1; o.adder = 2'd2; end
            4'hB: if (!fz) begin o.pc_we = 1'b1; o.adder = 2'd2; end
            4'hC: begin o.pc_we = 1'b1; o.adder = 2'd3; end
            default: ;
        endcase
        push(ins, rbit(), fz, 1'b1, o);
        if (op == 4'h8 || op == 4'h9) begin
            for (int i = 0; i < wm; i++) begin
                if (i == abort_at) begin
                    push_rst();
                    return;
                end
                o = '0; o.mem_req = 1'b1;
                push(ins, 1'b0, rbit(), 1'b1, o);
            end
            o = '0; o.mem_req = 1'b1;
            if (op == 4'h9) o.ram_we = 1'b1; else o.mdr_we = 1'b1;
            push(ins, 1'b1, rbit(), 1'b1, o);
        end
        if ((op >= 4'h1 && op <= 4'h6) || op == 4'h8) begin
            o = '0; o.rf_we = 1'b1; o.dataw = (op == 4'h8) ? 2'd1 : 2'd0;
            push(ins, rbit(), rbit(), 1'b1, o);
        end
        m_instret = m_instret + 16'd1;
    endtask

    // driver: one planned cycle per clock, applied just after the rising edge
    initial begin
        rec_t r;
        rst_n = 1'b0; instr = '0; flag_z = 1'b0; mem_rdy = 1'b0;
        m_instret = 16'd0;
        push_rst(); push_rst();
        plan(16'h1123, 0, 0, -1, -1, 0);          // ADD
        plan(16'h8123, 0, 3, -1, -1, 0);          // LD, 3 wait states
        plan(16'h9123, 1, 2, -1, -1, 0);          // ST
        plan(16'hA0FE, 0, 0,  1, -1, 0);          // BEQ taken
        plan(16'hA0FE, 0, 0,  0, -1, 0);          // BEQ not taken
        plan(16'hD000, 0, 0, -1, -1, 20);         // illegal -> HALT
        push_rst();
        plan(16'h8123, 0, 3, -1,  1, 0);          // LD aborted by reset in MEM
        plan(16'h0000, 0, 0, -1, -1, 0);
        plan(16'h0000, 1, 0, -1, -1, 0);
        plan(16'h0000, 0, 0, -1, -1, 0);
        for (int k = 0; k < 150; k++)
            plan({4'($urandom_range(0, 12)), 12'($urandom)},
                 $urandom_range(0, 2), $urandom_range(0, 3), -1, -1, 0);
        plan(16'hF000, 0, 0, -1, -1, 5);          // HLT: halted, not illegal
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            @(posedge clk); #1;
            rst_n = r.rstn; instr = r.ins; mem_rdy = r.rdy; flag_z = r.fz;
            exp_q.push_back(r);
        end
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // monitor: compare DUT outputs mid-cycle against the oldest expectation
    always @(negedge clk) begin
        rec_t  e;
        outs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            a = {pc_we, ir_we, rf_we, ram_we, mar_we, mdr_we, acc_we, rega_we,
                 regb_we, flags_we, alu_op, mux_pc_sel, mux_adder_sel, mux_reg2_sel,
                 mux_alu_sel, mux_dataw_sel, mem_req, halted, illegal};
            n_checks++;
            if (a !== e.exp) begin
                n_errors++;
                $display("FAIL outs cyc=%0d instr=%h got=%h want=%h", cyc, e.ins, a, e.exp);
            end
`ifdef CU_INSTRET_CNT_EN
            n_checks++;
            if (instret !== e.ir) begin
                n_errors++;
                $display("FAIL instret cyc=%0d got=%0d want=%0d", cyc, instret, e.ir);
            end
`endif
        end
    end

endmodule
